// File: rtl/m2_sprime_fetch_if.sv
// Bus bundle for the S' fetch stage: start/done control, SRAM read port,
// DP RAM write port and the block handshake toward the IDCT compute stage.
interface m2_sprime_fetch_if;
    logic        start;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [6:0]  dp_address;
    logic [15:0] dp_write_data;
    logic        dp_wren;
    logic        block_valid;
    logic        block_bank;
    logic [1:0]  block_seg;
    logic        block_taken;
    logic        done;

    modport master (
        input  start, SRAM_read_data, block_taken,
        output SRAM_address, SRAM_we_n, dp_address, dp_write_data, dp_wren,
               block_valid, block_bank, block_seg, done
    );

    modport slave (
        output start, SRAM_read_data, block_taken,
        input  SRAM_address, SRAM_we_n, dp_address, dp_write_data, dp_wren,
               block_valid, block_bank, block_seg, done
    );
endinterface

// File: rtl/m2_sprime_fetch.sv
// S' fetch stage: streams 8x8 coefficient blocks (Y, then U, then V) from SRAM
// into a two-bank DP RAM and hands each filled bank to the IDCT via valid/taken.
module m2_sprime_fetch #(
    parameter logic [17:0] SPRIME_BASE = 18'd76800,
    parameter int unsigned Y_WIDTH     = 320,
    parameter int unsigned UV_WIDTH    = 160,
    parameter int unsigned IMG_ROWS    = 240
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    m2_sprime_fetch_if.master bus
);
    localparam logic [17:0] U_BASE     = SPRIME_BASE + 18'(Y_WIDTH * IMG_ROWS);
    localparam logic [17:0] V_BASE     = U_BASE + 18'(UV_WIDTH * IMG_ROWS);
    localparam logic [17:0] Y_W        = 18'(Y_WIDTH);
    localparam logic [17:0] UV_W       = 18'(UV_WIDTH);
    localparam logic [7:0]  Y_BC_LAST  = 8'(Y_WIDTH / 8 - 1);
    localparam logic [7:0]  UV_BC_LAST = 8'(UV_WIDTH / 8 - 1);
    localparam logic [7:0]  BR_LAST    = 8'(IMG_ROWS / 8 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       plane_q;
    logic [7:0]       br_q, bc_q;
    logic [17:0]      brow_q;     // address of row br*8 of the current plane
    logic [17:0]      blk_q;      // address of element 0 of the current block
    logic [17:0]      line_q;     // address of element (r,0) being issued
    logic [17:0]      addr_q;
    logic [5:0]       elem_q;
    logic [1:0]       drain_q;
    logic             v1_q, v2_q, v3_q;
    logic [5:0]       e1_q, e2_q, e3_q;
    logic [1:0]       fcount_q;
    logic             wbank_q, rbank_q;
    logic [1:0][1:0]  seg_q;      // plane tag per bank; read/write pointers are the banks
    logic             done_q;

    logic [17:0] row_w;
    logic [7:0]  bc_last;
    logic        blk_done, take, last_blk;

    assign row_w    = (plane_q == 2'd0) ? Y_W : UV_W;
    assign bc_last  = (plane_q == 2'd0) ? Y_BC_LAST : UV_BC_LAST;
    assign blk_done = (state_q == S_DRAIN) && (drain_q == 2'd2);
    assign take     = bus.block_taken && (fcount_q != 2'd0);
    assign last_blk = (plane_q == 2'd2) && (br_q == BR_LAST) && (bc_q == bc_last);

    // Control FSM plus block/element address generation
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            plane_q <= '0;
            br_q    <= '0;
            bc_q    <= '0;
            brow_q  <= '0;
            blk_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            elem_q  <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_CHECK;
                        plane_q <= '0;
                        br_q    <= '0;
                        bc_q    <= '0;
                        brow_q  <= SPRIME_BASE;
                        blk_q   <= SPRIME_BASE;
                    end
                end
                S_CHECK: begin
                    if (fcount_q < 2'd2) begin
                        state_q <= S_FETCH;
                        addr_q  <= blk_q;
                        line_q  <= blk_q;
                        elem_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (elem_q == 6'd63) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end else begin
                        elem_q <= elem_q + 6'd1;
                        if (elem_q[2:0] == 3'd7) begin
                            line_q <= line_q + row_w;
                            addr_q <= line_q + row_w;
                        end else begin
                            addr_q <= addr_q + 18'd1;
                        end
                    end
                end
                default: begin
                    if (drain_q == 2'd2) begin
                        state_q <= last_blk ? S_IDLE : S_CHECK;
                        if (bc_q == bc_last) begin
                            bc_q <= '0;
                            if (br_q == BR_LAST) begin
                                br_q    <= '0;
                                plane_q <= plane_q + 2'd1;
                                brow_q  <= (plane_q == 2'd0) ? U_BASE : V_BASE;
                                blk_q   <= (plane_q == 2'd0) ? U_BASE : V_BASE;
                            end else begin
                                br_q   <= br_q + 8'd1;
                                brow_q <= brow_q + (row_w << 3);
                                blk_q  <= brow_q + (row_w << 3);
                            end
                        end else begin
                            bc_q  <= bc_q + 8'd1;
                            blk_q <= blk_q + 18'd8;
                        end
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
            endcase
        end
    end

    // Three-stage issue pipeline matching the fixed SRAM read latency
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            e1_q <= '0;
            e2_q <= '0;
            e3_q <= '0;
        end else begin
            v1_q <= (state_q == S_FETCH);
            e1_q <= elem_q;
            v2_q <= v1_q;
            e2_q <= e1_q;
            v3_q <= v2_q;
            e3_q <= e2_q;
        end
    end

    // Bank handshake: full count, write/read bank pointers and plane tags
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            fcount_q <= '0;
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            seg_q    <= '0;
        end else begin
            if (blk_done) begin
                seg_q[wbank_q] <= plane_q;
                wbank_q        <= ~wbank_q;
            end
            if (take) begin
                rbank_q <= ~rbank_q;
            end
            if (blk_done && !take) begin
                fcount_q <= fcount_q + 2'd1;
            end else if (!blk_done && take) begin
                fcount_q <= fcount_q - 2'd1;
            end
        end
    end

    // End-of-frame pulse, one cycle after the final write of the last block
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= blk_done && last_blk;
        end
    end

    assign bus.SRAM_address  = addr_q;
    assign bus.SRAM_we_n     = 1'b1;
    assign bus.dp_address    = {wbank_q, e3_q};
    assign bus.dp_write_data = v3_q ? bus.SRAM_read_data : '0;
    assign bus.dp_wren       = v3_q;
    assign bus.block_valid   = (fcount_q != 2'd0);
    assign bus.block_bank    = rbank_q;
    assign bus.block_seg     = seg_q[rbank_q];
    assign bus.done          = done_q;
endmodule

// File: tb/tb_m2_sprime_fetch.sv
// Directed bench for m2_sprime_fetch: full-size instance for addressing,
// backpressure and reset; reduced-geometry instance for plane order and done.
// Cycle 0 of a run is the cycle following the clock edge that samples start.
module tb_m2_sprime_fetch;
    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    always #10 clk = ~clk;

    m2_sprime_fetch_if a_if ();
    m2_sprime_fetch_if b_if ();

    m2_sprime_fetch dut_a (
        .CLOCK_50_I(clk),
        .resetn    (resetn),
        .bus       (a_if)
    );

    m2_sprime_fetch #(
        .Y_WIDTH (16),
        .UV_WIDTH(8),
        .IMG_ROWS(16)
    ) dut_b (
        .CLOCK_50_I(clk),
        .resetn    (resetn),
        .bus       (b_if)
    );

    // SRAM model: 3-cycle read latency, word content derived from its address
    function automatic logic [15:0] sram_word(input logic [17:0] a);
        return a[15:0] ^ 16'h3C5A;
    endfunction

    logic [17:0] a_p1, a_p2, a_p3, b_p1, b_p2, b_p3;

    // SRAM read pipelines for both instances
    always @(posedge clk) begin
        a_p1 <= a_if.SRAM_address;
        a_p2 <= a_p1;
        a_p3 <= a_p2;
        b_p1 <= b_if.SRAM_address;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end

    assign a_if.SRAM_read_data = sram_word(a_p3);
    assign b_if.SRAM_read_data = sram_word(b_p3);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_addr"},  32'(a_if.SRAM_address), 0);
        check({tag, "_we_n"},  32'(a_if.SRAM_we_n), 1);
        check({tag, "_dpa"},   32'(a_if.dp_address), 0);
        check({tag, "_dpd"},   32'(a_if.dp_write_data), 0);
        check({tag, "_wren"},  32'(a_if.dp_wren), 0);
        check({tag, "_valid"}, 32'(a_if.block_valid), 0);
        check({tag, "_bank"},  32'(a_if.block_bank), 0);
        check({tag, "_seg"},   32'(a_if.block_seg), 0);
        check({tag, "_done"},  32'(a_if.done), 0);
    endtask

    initial begin
        resetn           = 1'b0;
        a_if.start       = 1'b0;
        a_if.block_taken = 1'b0;
        b_if.start       = 1'b0;
        b_if.block_taken = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        check("rst_b_valid", 32'(b_if.block_valid), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Immediate-taken consumer, reset asserted while block 5 is fetching
        a_if.start = 1'b1;
        for (int cyc = 0; cyc <= 350; cyc++) begin
            @(negedge clk);
            a_if.start = 1'b0;
            if (cyc == 350) begin
                check("blk5_wren", 32'(a_if.dp_wren), 1);
                check("blk5_addr", 32'(a_if.SRAM_address), 77161);
            end
            a_if.block_taken = a_if.block_valid;
        end
        resetn           = 1'b0;
        a_if.block_taken = 1'b0;
        #1;
        check_reset_a("midrst");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Fresh start after reset, no stalls: addressing and write timing
        a_if.start = 1'b1;
        for (int cyc = 0; cyc <= 2721; cyc++) begin
            @(negedge clk);
            a_if.start = 1'b0;
            if (cyc >= 1 && cyc <= 8)
                check("row0_addr", 32'(a_if.SRAM_address), 32'(76800 + cyc - 1));
            case (cyc)
                3: check("wr_not_yet", 32'(a_if.dp_wren), 0);
                4: begin
                    check("wr0_wren", 32'(a_if.dp_wren), 1);
                    check("wr0_dpa",  32'(a_if.dp_address), 0);
                    check("wr0_data", 32'(a_if.dp_write_data), 32'(sram_word(18'd76800)));
                end
                9: check("row1_addr", 32'(a_if.SRAM_address), 77120);
                67: begin
                    check("wr63_dpa",  32'(a_if.dp_address), 63);
                    check("wr63_data", 32'(a_if.dp_write_data), 32'(sram_word(18'd79047)));
                    check("valid_pre", 32'(a_if.block_valid), 0);
                end
                68: begin
                    check("valid_rise", 32'(a_if.block_valid), 1);
                    check("bank0",      32'(a_if.block_bank), 0);
                    check("seg_y",      32'(a_if.block_seg), 0);
                end
                69: check("blk1_addr", 32'(a_if.SRAM_address), 76808);
                72: check("blk1_dpa",  32'(a_if.dp_address), 64);
                2721: check("blk40_addr", 32'(a_if.SRAM_address), 79360);
                default: ;
            endcase
            a_if.block_taken = a_if.block_valid;
        end
        a_if.block_taken = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Stalled consumer, ignored taken, taken coincident with completion
        a_if.start = 1'b1;
        for (int cyc = 0; cyc <= 223; cyc++) begin
            @(negedge clk);
            a_if.start       = 1'b0;
            a_if.block_taken = 1'b0;
            case (cyc)
                10: a_if.block_taken = 1'b1;
                11: begin
                    check("ign_valid", 32'(a_if.block_valid), 0);
                    check("ign_bank",  32'(a_if.block_bank), 0);
                end
                68: check("ign_bank68", 32'(a_if.block_bank), 0);
                140: begin
                    check("stall_wren",  32'(a_if.dp_wren), 0);
                    check("stall_addr",  32'(a_if.SRAM_address), 79055);
                    check("stall_valid", 32'(a_if.block_valid), 1);
                    check("stall_bank",  32'(a_if.block_bank), 0);
                end
                150: a_if.block_taken = 1'b1;
                151: begin
                    check("take_bank",  32'(a_if.block_bank), 1);
                    check("take_valid", 32'(a_if.block_valid), 1);
                end
                152: check("resume_addr", 32'(a_if.SRAM_address), 76816);
                155: begin
                    check("resume_wren", 32'(a_if.dp_wren), 1);
                    check("resume_dpa",  32'(a_if.dp_address), 0);
                end
                218: a_if.block_taken = 1'b1;
                219: begin
                    check("coin_bank",  32'(a_if.block_bank), 0);
                    check("coin_valid", 32'(a_if.block_valid), 1);
                end
                220: check("coin_addr", 32'(a_if.SRAM_address), 76824);
                223: begin
                    check("coin_wren", 32'(a_if.dp_wren), 1);
                    check("coin_dpa",  32'(a_if.dp_address), 64);
                end
                default: ;
            endcase
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reduced frame (Y 2x2, U 1x2, V 1x2 blocks): plane order and done
        b_if.start = 1'b1;
        for (int cyc = 0; cyc <= 546; cyc++) begin
            @(negedge clk);
            b_if.start = 1'b0;
            if (b_if.done) n_done++;
            case (cyc)
                1:   check("b_blk0_addr", 32'(b_if.SRAM_address), 76800);
                137: check("b_blk2_addr", 32'(b_if.SRAM_address), 76928);
                145: check("b_blk2_row1", 32'(b_if.SRAM_address), 76944);
                273: check("b_u_addr",    32'(b_if.SRAM_address), 77056);
                340: begin
                    check("b_u_seg",   32'(b_if.block_seg), 1);
                    check("b_u_valid", 32'(b_if.block_valid), 1);
                end
                341: check("b_u1_addr",  32'(b_if.SRAM_address), 77120);
                409: check("b_v_addr",   32'(b_if.SRAM_address), 77184);
                476: check("b_v_seg",    32'(b_if.block_seg), 2);
                477: check("b_v1_addr",  32'(b_if.SRAM_address), 77248);
                543: check("b_done_pre", 32'(b_if.done), 0);
                544: check("b_done",     32'(b_if.done), 1);
                545: check("b_done_end", 32'(b_if.done), 0);
                546: check("b_idle_wren", 32'(b_if.dp_wren), 0);
                default: ;
            endcase
            b_if.block_taken = b_if.block_valid;
        end
        check("b_done_count", 32'(n_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
